module_instruction_fetch: RTL and testbench
===========================================

# module_instruction_fetch

Fetch stage placed directly downstream of `module_program_counter`. It captures the current `addr`, issues a single outstanding read to instruction memory over a valid/ready request channel, and presents the returned word to the decoder with a valid/ready handshake. It drives `fetch_stall` so the PC holds until the instruction is consumed. It discards fetches killed by a control-flow `flush`, and raises a sticky fault on a misaligned address or a memory timeout.

## Interface
- `TIMEOUT_CYCLES`, 16: number of cycles spent in WAIT without a response before FAULT is entered (≥2).
- `NOP_INSTR`, 32'h00000013: value driven on `instr` at reset.

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `pc_addr` in 32: current PC (`addr` output of `module_program_counter`).
- `flush` in 1: redirect pulse, asserted in the cycle the PC loads a jump/branch target.
- `mem_req_valid` out 1: read request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out 32: word-aligned fetch address.
- `mem_resp_valid` in 1: read data valid. There is no backpressure on this channel.
- `mem_resp_data` in 32: instruction word.
- `instr_valid` out 1: `instr`/`instr_addr` valid for the decoder.
- `instr_ready` in 1: decoder consumes the instruction.
- `instr` out 32: fetched instruction.
- `instr_addr` out 32: address of `instr`.
- `fetch_stall` out 1: PC must hold its value.
- `fetch_fault` out 1: sticky fault (misaligned address or timeout).

## Operation
- States: IDLE, REQ, WAIT, HOLD, FAULT. Internal registers: `fetch_addr[31:0]`, `kill`, `tmo_cnt[$clog2(TIMEOUT_CYCLES+1)-1:0]`.
- **IDLE**
  - With `flush`=1: stay in IDLE, because the PC changes at this edge.
  - Otherwise capture `fetch_addr <= pc_addr` and clear `kill`.
  - If `pc_addr[1:0] != 0`, go to FAULT. Otherwise go to REQ.
- **REQ**
  - `mem_req_valid`=1 and `mem_req_addr`=`fetch_addr`; both are held stable until `mem_req_ready`. A request is never withdrawn.
  - `flush` sets `kill`.
  - On `mem_req_ready`, go to WAIT with `tmo_cnt` cleared.
- **WAIT**
  - `flush` sets `kill`.
  - On `mem_resp_valid`:
    - If `kill` is set or `flush` is high this cycle, drop the data and go to IDLE.
    - Otherwise latch `instr <= mem_resp_data` and `instr_addr <= fetch_addr`, then go to HOLD.
  - With no response, `tmo_cnt` increments. When `tmo_cnt == TIMEOUT_CYCLES-1`, go to IDLE if `kill` (or `flush`) is set, otherwise go to FAULT.
- **HOLD**
  - `instr_valid`=1.
  - `flush` takes priority over `instr_ready`: drop the instruction and go to IDLE.
  - On `instr_ready`, go to IDLE.
- **FAULT**
  - `fetch_fault`=1 and `instr_valid`=0.
  - Leave only on `flush`, going to IDLE with `fetch_fault` cleared at that edge.
- `fetch_stall` = ~(state==HOLD & `instr_ready` & ~`flush`). The flush source overrides the stall when redirecting the PC.
- `mem_resp_valid` is ignored outside WAIT. There is at most one outstanding request.
- `reset` takes priority in every state, including mid-request. An in-flight response arriving after reset is ignored because the block is not in WAIT.

## Timing
- Reset values:
  - state = IDLE.
  - `mem_req_valid`=0, `mem_req_addr`=0.
  - `instr_valid`=0, `instr`=`NOP_INSTR`, `instr_addr`=0.
  - `fetch_stall`=1, `fetch_fault`=0.
  - `kill`=0, `tmo_cnt`=0.
- Best case, with `mem_req_ready` high and a 1-cycle response:
  - Cycle 0: IDLE.
  - Cycle 1: REQ, accepted.
  - Cycle 2: WAIT, response arrives.
  - Cycle 3: HOLD, `instr_valid`=1. If `instr_ready`, `fetch_stall`=0 and the PC advances.
  - Cycle 4: IDLE, new address captured.
  - Throughput is therefore 1 instruction per 4 cycles.
- `mem_req_addr` and `instr` are registered outputs. `fetch_stall` is combinational from state, `instr_ready` and `flush`.
- A timeout fault is entered exactly `TIMEOUT_CYCLES` cycles after the first WAIT cycle when no response arrives.

## Test plan
- **Reset then fetch:** reset for 2 cycles, `pc_addr`=0x00000000, memory ready and returns 0x00500093 one cycle after accept, `instr_ready`=1.
  - Required: `mem_req_valid` in cycle 1; `instr_valid`=1, `instr`=0x00500093, `instr_addr`=0 in cycle 3; `fetch_stall`=0 only in cycle 3.
- **Backpressure:**
  - `mem_req_ready` low for 3 cycles → `mem_req_addr` is held at 0x00000004 throughout.
  - `instr_ready` low for 2 cycles in HOLD → `instr` is stable and `fetch_stall`=1 throughout.
- **Flush in WAIT:** `fetch_addr`=0x8, pulse `flush`, response 0xDEADBEEF arrives 2 cycles later.
  - Required: `instr_valid` never rises for 0xDEADBEEF; the block returns to IDLE and next fetches the new `pc_addr`=0x40.
- **Flush coincident with `instr_ready` in HOLD:** `instr_valid` deasserts next cycle and `fetch_stall` stays 1.
- **Misaligned address:** `pc_addr`=0x00000006.
  - Required: no `mem_req_valid`; `fetch_fault`=1 from the next cycle; `fetch_fault` is cleared by a `flush` to 0x10, which is then fetched normally.
- **Timeout:** `mem_resp_valid` held low with `TIMEOUT_CYCLES`=16.
  - Required: `fetch_fault` rises exactly 16 cycles after entering WAIT.
  - Repeat with reset asserted in cycle 5 of WAIT → all outputs return to their reset values and the late response is ignored.

Source files
------------

// File: rtl/module_instruction_fetch.sv
// -----------------------------------------------------------------------------
// module_instruction_fetch
//
// Fetch stage sitting directly behind module_program_counter. It captures the
// current PC and issues one read to instruction memory at a time. The returned
// word is then held for the decoder under a valid/ready handshake. While a
// fetch is in progress, fetch_stall holds the PC. A fetch killed by a
// control-flow flush is discarded. A misaligned PC, or a memory that never
// answers, parks the block in a sticky FAULT state until the next flush.
//
// Parameters
//   TIMEOUT_CYCLES  cycles spent in WAIT without a response before FAULT (>= 2)
//   NOP_INSTR       value presented on instr out of reset
//
// Ports
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   pc_addr         current PC from module_program_counter
//   flush           redirect pulse, high in the cycle the PC loads a new target
//   mem_req_valid   read request valid (held until mem_req_ready)
//   mem_req_ready   memory accepts the request
//   mem_req_addr    registered, word-aligned fetch address
//   mem_resp_valid  read data valid (no backpressure, honoured only in WAIT)
//   mem_resp_data   returned instruction word
//   instr_valid     instr / instr_addr valid for the decoder
//   instr_ready     decoder consumes the instruction
//   instr           registered fetched instruction
//   instr_addr      registered address of instr
//   fetch_stall     PC must hold its value
//   fetch_fault     sticky fault (misaligned address or response timeout)
// -----------------------------------------------------------------------------
module module_instruction_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_addr,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  output logic        fetch_stall,
  output logic        fetch_fault
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [31:0]      fetch_addr, fetch_addr_next;
  logic             kill, kill_next;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_next;
  logic             load_instr;
  logic [31:0]      instr_q, instr_addr_q;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      fetch_addr   <= '0;
      kill         <= 1'b0;
      tmo_cnt      <= '0;
      // NOTE: the instruction holding registers are reset as well, because
      // instr/instr_addr are visible outputs with defined reset values.
      instr_q      <= NOP_INSTR;
      instr_addr_q <= '0;
    end else begin
      state      <= state_next;
      fetch_addr <= fetch_addr_next;
      kill       <= kill_next;
      tmo_cnt    <= tmo_cnt_next;
      if (load_instr) begin
        instr_q      <= mem_resp_data;
        instr_addr_q <= fetch_addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here receives a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_next      = state;
    fetch_addr_next = fetch_addr;
    kill_next       = kill;
    tmo_cnt_next    = tmo_cnt;
    load_instr      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // A flush here means the PC is changing at this edge, so wait a
        // cycle and capture the redirected address instead.
        if (!flush) begin
          fetch_addr_next = pc_addr;
          kill_next       = 1'b0;
          state_next      = (pc_addr[1:0] != 2'b00) ? ST_FAULT : ST_REQ;
        end
      end

      ST_REQ: begin
        // The request stays up even if it has been killed. The response is
        // then dropped in WAIT, which keeps the memory protocol simple.
        if (flush) kill_next = 1'b1;
        if (mem_req_ready) begin
          state_next   = ST_WAIT;
          tmo_cnt_next = '0;
        end
      end

      ST_WAIT: begin
        if (flush) kill_next = 1'b1;
        if (mem_resp_valid) begin
          if (kill || flush) begin
            state_next = ST_IDLE;
          end else begin
            load_instr = 1'b1;
            state_next = ST_HOLD;
          end
        end else begin
          tmo_cnt_next = tmo_cnt + TMO_W'(1);
          // A killed fetch that times out is simply abandoned. Only a live
          // fetch raises the fault.
          if (tmo_cnt == TMO_LAST) begin
            state_next = (kill || flush) ? ST_IDLE : ST_FAULT;
          end
        end
      end

      ST_HOLD: begin
        // flush wins over instr_ready: the held word belongs to the old path.
        if (flush || instr_ready) state_next = ST_IDLE;
      end

      ST_FAULT: begin
        if (flush) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_req_valid = (state == ST_REQ);
  assign mem_req_addr  = fetch_addr;
  assign instr_valid   = (state == ST_HOLD);
  assign instr         = instr_q;
  assign instr_addr    = instr_addr_q;
  assign fetch_fault   = (state == ST_FAULT);

  // The PC may advance only when the decoder takes the word on the current
  // path. During a flush the redirect source drives the PC, not this stage.
  assign fetch_stall   = ~((state == ST_HOLD) & instr_ready & ~flush);

endmodule

// File: tb/tb_module_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_module_instruction_fetch
//
// Directed bench for module_instruction_fetch. The bench drives inputs just
// after each rising edge and samples outputs at the falling edge. Words
// returned by the modelled memory on a live fetch go into a queue, and each
// one is popped and compared when the decoder sees it in HOLD.
// -----------------------------------------------------------------------------
module tb_module_instruction_fetch;

  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_addr;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        fetch_stall;
  logic        fetch_fault;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  module_instruction_fetch #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .NOP_INSTR     (NOP_INSTR)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pc_addr       (pc_addr),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_addr    (instr_addr),
    .fetch_stall   (fetch_stall),
    .fetch_fault   (fetch_fault)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pops the next expected word and compares the decoder-facing outputs.
  task automatic check_instr(input string tag);
    exp_t e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s observed=instr_valid expected=empty_scoreboard", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
      check({tag, "_instr"}, instr, e.data);
      check({tag, "_addr"}, instr_addr, e.addr);
    end
  endtask

  // Drives a one-cycle memory response. Live fetches get scoreboarded.
  task automatic respond(input logic [31:0] data, input logic [31:0] addr, input bit live);
    exp_t e;
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    if (live) begin
      e.data = data;
      e.addr = addr;
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
    check({tag, "_req_addr"}, mem_req_addr, 32'd0);
    check({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_instr"}, instr, NOP_INSTR);
    check({tag, "_instr_addr"}, instr_addr, 32'd0);
    check({tag, "_stall"}, {31'd0, fetch_stall}, 32'd1);
    check({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    pc_addr        = 32'd0;
    flush          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'd0;
    instr_ready    = 1'b0;

    // Reset held across two rising edges.
    tick();
    mid(); check_reset_values("rst");
    tick();
    reset = 1'b0;

    // ---------------- Reset then fetch ----------------
    pc_addr = 32'h0; mem_req_ready = 1'b1; instr_ready = 1'b1;
    mid();  // cycle 0: IDLE
    check("c0_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("c0_stall", {31'd0, fetch_stall}, 32'd1);
    tick();
    mid();  // cycle 1: REQ
    check("c1_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("c1_req_addr", mem_req_addr, 32'h0);
    check("c1_stall", {31'd0, fetch_stall}, 32'd1);
    tick();
    respond(32'h0050_0093, 32'h0, 1'b1);
    mid();  // cycle 2: WAIT
    check("c2_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("c2_stall", {31'd0, fetch_stall}, 32'd1);
    tick();
    mem_resp_valid = 1'b0;
    mid();  // cycle 3: HOLD
    check_instr("c3");
    check("c3_stall", {31'd0, fetch_stall}, 32'd0);
    tick();
    pc_addr = 32'h4;  // PC advanced on the unstalled edge
    mem_req_ready = 1'b0;
    mid();  // cycle 4: IDLE
    check("c4_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("c4_stall", {31'd0, fetch_stall}, 32'd1);
    tick();

    // ---------------- Backpressure on the request ----------------
    for (int i = 0; i < 3; i++) begin
      mid();
      check("bp_req_valid", {31'd0, mem_req_valid}, 32'd1);
      check("bp_req_addr", mem_req_addr, 32'h4);
      tick();
    end
    mem_req_ready = 1'b1;
    mid();
    check("bp_req_accept_addr", mem_req_addr, 32'h4);
    tick();
    respond(32'h00a0_0113, 32'h4, 1'b1);
    tick();
    mem_resp_valid = 1'b0;

    // ---------------- Backpressure from the decoder ----------------
    instr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mid();
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", instr, 32'h00a0_0113);
      check("hold_stall", {31'd0, fetch_stall}, 32'd1);
      tick();
    end
    instr_ready = 1'b1;
    mid();
    check_instr("hold_take");
    check("hold_take_stall", {31'd0, fetch_stall}, 32'd0);
    tick();
    pc_addr = 32'h8;
    tick();  // IDLE captures 0x8
    mid();
    check("fw_req_addr", mem_req_addr, 32'h8);
    tick();  // REQ accepted

    // ---------------- Flush in WAIT ----------------
    flush = 1'b1;  // first WAIT cycle, PC loads 0x40 at this edge
    mid();
    check("fw_stall", {31'd0, fetch_stall}, 32'd1);
    tick();
    flush = 1'b0; pc_addr = 32'h40;
    tick();
    respond(32'hDEAD_BEEF, 32'h8, 1'b0);
    mid();
    check("fw_resp_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    mid();  // back in IDLE, killed data never shown
    check("fw_drop_valid", {31'd0, instr_valid}, 32'd0);
    check("fw_drop_instr", instr, 32'h00a0_0113);
    tick();
    mid();
    check("fw_new_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("fw_new_req_addr", mem_req_addr, 32'h40);
    tick();
    respond(32'h0000_0293, 32'h40, 1'b1);
    tick();
    mem_resp_valid = 1'b0;

    // ---------------- Flush coincident with instr_ready ----------------
    flush = 1'b1; instr_ready = 1'b1;
    mid();
    check_instr("fh");
    check("fh_stall", {31'd0, fetch_stall}, 32'd1);
    tick();
    flush = 1'b0; pc_addr = 32'h80;
    mid();
    check("fh_next_valid", {31'd0, instr_valid}, 32'd0);
    check("fh_next_stall", {31'd0, fetch_stall}, 32'd1);
    tick();
    mid();
    check("fh_req_addr", mem_req_addr, 32'h80);
    tick();
    respond(32'h1234_5678, 32'h80, 1'b1);
    tick();
    mem_resp_valid = 1'b0;
    mid();
    check_instr("fh_refetch");
    tick();

    // ---------------- Misaligned address ----------------
    pc_addr = 32'h6;
    mid();
    check("mis_idle_req", {31'd0, mem_req_valid}, 32'd0);
    check("mis_idle_fault", {31'd0, fetch_fault}, 32'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      mid();
      check("mis_fault", {31'd0, fetch_fault}, 32'd1);
      check("mis_req_valid", {31'd0, mem_req_valid}, 32'd0);
      check("mis_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("mis_stall", {31'd0, fetch_stall}, 32'd1);
      tick();
    end
    flush = 1'b1;
    mid();
    check("mis_flush_fault", {31'd0, fetch_fault}, 32'd1);
    tick();
    flush = 1'b0; pc_addr = 32'h10;
    mid();
    check("mis_cleared", {31'd0, fetch_fault}, 32'd0);
    tick();
    mid();
    check("mis_req_addr", mem_req_addr, 32'h10);
    check("mis_req_valid2", {31'd0, mem_req_valid}, 32'd1);
    tick();
    respond(32'hABCD_EF01, 32'h10, 1'b1);
    tick();
    mem_resp_valid = 1'b0;
    mid();
    check_instr("mis_refetch");
    tick();

    // ---------------- Timeout ----------------
    pc_addr = 32'h14;
    tick();  // IDLE
    tick();  // REQ accepted, now in first WAIT cycle
    for (int i = 0; i < int'(TIMEOUT_CYCLES); i++) begin
      mid();
      check("tmo_wait_fault", {31'd0, fetch_fault}, 32'd0);
      tick();
    end
    mid();
    check("tmo_fault", {31'd0, fetch_fault}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0; pc_addr = 32'h20;
    tick();  // IDLE captures 0x20
    tick();  // REQ accepted
    for (int i = 0; i < 4; i++) tick();  // now in the fifth WAIT cycle
    reset = 1'b1;
    mid();
    check("tmo_rst_pre_fault", {31'd0, fetch_fault}, 32'd0);
    tick();
    reset = 1'b0; mem_req_ready = 1'b0;
    respond(32'hBADB_AD00, 32'h20, 1'b0);  // late response after reset
    mid();
    check_reset_values("tmo_rst");
    tick();
    mid();  // REQ, response still arriving but ignored
    check("late_valid", {31'd0, instr_valid}, 32'd0);
    check("late_instr", instr, NOP_INSTR);
    check("late_req_addr", mem_req_addr, 32'h20);
    tick();
    mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
    tick();  // REQ accepted
    respond(32'h0010_0073, 32'h20, 1'b1);
    tick();
    mem_resp_valid = 1'b0;
    mid();
    check_instr("final");
    tick();

    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
